// File: rtl/astra_pifo_if.sv
// astra_pifo_if: parent-facing and child-facing signals of one 4-way PIFO node.
// The slave modport is the node itself; the master side drives requests and child heads.
interface astra_pifo_if #(
    parameter int PTW = 16,
    parameter int MTW = 32
);
    localparam int W = MTW + PTW;
    logic           i_push;
    logic [W-1:0]   i_push_data;
    logic           i_pop;
    logic [W-1:0]   o_pop_data;
    logic           o_ready;
    logic [3:0]     o_push;
    logic [W-1:0]   o_push_data;
    logic [3:0]     o_pop;
    logic [4*W-1:0] i_pop_data;
    logic [W-1:0]   o_best_data;
    modport slave (
        input  i_push, i_push_data, i_pop, i_pop_data,
        output o_pop_data, o_ready, o_push, o_push_data, o_pop, o_best_data
    );
    modport master (
        output i_push, i_push_data, i_pop, i_pop_data,
        input  o_pop_data, o_ready, o_push, o_push_data, o_pop, o_best_data
    );
endinterface

// File: rtl/astra_pifo.sv
// astra_pifo: one 4-way PIFO tree node; each slot holds the minimum of its child subtree.
// Overflow sinks to the least-loaded child, pops refill the emptied slot from that child's head.
module astra_pifo #(
    parameter int PTW = 16,
    parameter int MTW = 32,
    parameter int CTW = 10
) (
    input  logic         i_clk,
    input  logic         i_arst_n,
    astra_pifo_if.slave  bus
);
    localparam int W = MTW + PTW;
    logic [3:0]     v_q, v_d;
    logic [W-1:0]   slot_q [4];
    logic [W-1:0]   slot_d [4];
    logic [CTW-1:0] cnt_q [4];
    logic [CTW-1:0] cnt_d [4];
    logic [W-1:0]   pop_q, pop_d;
    logic [1:0]     m, fi, kc;
    logic           any_v, full;
    logic [W-1:0]   child;
    logic [PTW-1:0] pp;
    logic           keep_child, keep_slot;
    always_comb begin
        m     = '0;
        fi    = '0;
        kc    = '0;
        any_v = 1'b0;
        full  = &v_q;
        for (int k = 3; k >= 0; k--)
            if (!v_q[k]) fi = 2'(k);
        for (int k = 0; k < 4; k++) begin
            if (v_q[k] && (!any_v || slot_q[k][PTW-1:0] < slot_q[m][PTW-1:0])) begin
                m     = 2'(k);
                any_v = 1'b1;
            end
            if (cnt_q[k] < cnt_q[kc]) kc = 2'(k);
            if (cnt_q[k] != '1) full = 1'b0;
        end
    end
    assign child       = bus.i_pop_data[m*W +: W];
    assign pp          = bus.i_push_data[PTW-1:0];
    // On equal priority the entry already in the tree stays ahead of the new one
    assign keep_child  = child[PTW-1:0] <= pp;
    assign keep_slot   = slot_q[kc][PTW-1:0] <= pp;
    assign bus.o_ready = i_arst_n & ~full;
    assign bus.o_best_data = any_v ? slot_q[m] : '1;
    assign bus.o_pop_data  = pop_q;
    always_comb begin
        v_d             = v_q;
        slot_d          = slot_q;
        cnt_d           = cnt_q;
        pop_d           = pop_q;
        bus.o_push      = '0;
        bus.o_pop       = '0;
        bus.o_push_data = bus.i_push_data;
        if (bus.i_push && bus.i_pop) begin
            if (!any_v || pp < slot_q[m][PTW-1:0]) begin
                pop_d = bus.i_push_data;
            end else begin
                pop_d = slot_q[m];
                if (cnt_q[m] == '0) begin
                    slot_d[m] = bus.i_push_data;
                end else begin
                    slot_d[m]       = keep_child ? child : bus.i_push_data;
                    bus.o_push_data = keep_child ? bus.i_push_data : child;
                    bus.o_push[m]   = 1'b1;
                    bus.o_pop[m]    = 1'b1;
                end
            end
        end else if (bus.i_pop) begin
            pop_d = any_v ? slot_q[m] : '1;
            if (any_v && cnt_q[m] != '0) begin
                slot_d[m]    = child;
                bus.o_pop[m] = 1'b1;
                cnt_d[m]     = cnt_q[m] - 1'b1;
            end else if (any_v) begin
                v_d[m] = 1'b0;
            end
        end else if (bus.i_push && bus.o_ready) begin
            if (!(&v_q)) begin
                slot_d[fi] = bus.i_push_data;
                v_d[fi]    = 1'b1;
            end else begin
                slot_d[kc]      = keep_slot ? slot_q[kc] : bus.i_push_data;
                bus.o_push_data = keep_slot ? bus.i_push_data : slot_q[kc];
                bus.o_push[kc]  = 1'b1;
                cnt_d[kc]       = cnt_q[kc] + 1'b1;
            end
        end
    end
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            v_q   <= '0;
            pop_q <= '1;
            for (int k = 0; k < 4; k++) begin
                slot_q[k] <= '1;
                cnt_q[k]  <= '0;
            end
        end else begin
            v_q    <= v_d;
            pop_q  <= pop_d;
            slot_q <= slot_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_astra_pifo.sv
// tb_astra_pifo: drives one node with behavioural children and compares against
// a whole-tree priority multiset (min leaves first, earliest-inserted wins ties).
module tb_astra_pifo;
    localparam int PTW = 16;
    localparam int MTW = 32;
    localparam int CTW = 2;
    localparam int W   = MTW + PTW;
    localparam int CAP = 4 + 4 * ((1 << CTW) - 1);
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errs = 0;
    int   checks = 0;
    logic [W-1:0] mdl [$];
    logic [W-1:0] cq [4][$];
    logic [W-1:0] exp_pd = '1;
    logic [3:0]   cap_push, cap_pop;
    logic [W-1:0] cap_pd;
    bit           used [1 << PTW];
    astra_pifo_if #(.PTW(PTW), .MTW(MTW)) bus ();
    astra_pifo #(.PTW(PTW), .MTW(MTW), .CTW(CTW)) dut (
        .i_clk   (clk),
        .i_arst_n(rst_n),
        .bus     (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic int min_idx(input logic [W-1:0] q [$]);
        int b = -1;
        foreach (q[i])
            if (b < 0 || q[i][PTW-1:0] < q[b][PTW-1:0]) b = i;
        return b;
    endfunction
    function automatic logic [W-1:0] ent(input logic [15:0] p, input logic [31:0] meta);
        return {meta, p};
    endfunction
    task automatic refresh_heads();
        for (int k = 0; k < 4; k++) begin
            int b = min_idx(cq[k]);
            bus.i_pop_data[k*W +: W] = (b < 0) ? '1 : cq[k][b];
        end
    endtask
    // One clock: drive at negedge, capture child traffic, update models, check after the edge
    task automatic cycle(input logic push, input logic [W-1:0] d, input logic pop);
        int b;
        bus.i_push = push;
        bus.i_push_data = d;
        bus.i_pop = pop;
        #1;
        cap_push = bus.o_push;
        cap_pop  = bus.o_pop;
        cap_pd   = bus.o_push_data;
        b = min_idx(mdl);
        if (push && pop) begin
            if (b < 0 || d[PTW-1:0] < mdl[b][PTW-1:0]) exp_pd = d;
            else begin
                exp_pd = mdl[b];
                mdl.delete(b);
                mdl.push_back(d);
            end
        end else if (pop) begin
            exp_pd = (b < 0) ? '1 : mdl[b];
            if (b >= 0) mdl.delete(b);
        end else if (push && mdl.size() < CAP) begin
            mdl.push_back(d);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (cap_push[k]) cq[k].push_back(cap_pd);
            if (cap_pop[k]) begin
                int c = min_idx(cq[k]);
                if (c >= 0) cq[k].delete(c);
            end
        end
        refresh_heads();
        b = min_idx(mdl);
        check("pop_data", bus.o_pop_data, exp_pd);
        check("best", bus.o_best_data, (b < 0) ? '1 : mdl[b]);
        check("ready", W'(bus.o_ready), W'(mdl.size() < CAP));
        bus.i_push = 1'b0;
        bus.i_pop = 1'b0;
        @(negedge clk);
    endtask
    function automatic logic [W-1:0] rnd_ent();
        int p;
        do p = $urandom_range(0, 16'hFFFE); while (used[p]);
        used[p] = 1'b1;
        return ent(16'(p), $urandom);
    endfunction
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.i_push = 1'b0;
        bus.i_pop = 1'b0;
        bus.i_push_data = '0;
        bus.i_pop_data = '1;
        repeat (2) @(negedge clk);
        check("rst_ready", W'(bus.o_ready), '0);
        check("rst_push", W'(bus.o_push | bus.o_pop), '0);
        rst_n = 1'b1;
        #1;
        check("idle_ready", W'(bus.o_ready), W'(1));
        check("idle_pop_data", bus.o_pop_data, '1);
        check("idle_best", bus.o_best_data, '1);
        @(negedge clk);
        cycle(1, ent(50, 32'hAAAA), 0);
        cycle(1, ent(20, 32'hBBBB), 0);
        cycle(1, ent(80, 32'hCCCC), 0);
        cycle(1, ent(10, 32'hDDDD), 0);
        check("t2_best", bus.o_best_data, ent(10, 32'hDDDD));
        cycle(0, '0, 1);
        check("t2_pop", bus.o_pop_data, ent(10, 32'hDDDD));
        check("t2_best20", bus.o_best_data, ent(20, 32'hBBBB));
        cycle(1, ent(5, 32'hEEEE), 1);
        check("t3_bypass", bus.o_pop_data, ent(5, 32'hEEEE));
        check("t3_nochild", W'(cap_push | cap_pop), '0);
        check("t3_best", bus.o_best_data, ent(20, 32'hBBBB));
        cycle(0, '0, 1);
        check("t4_pop20", bus.o_pop_data, ent(20, 32'hBBBB));
        cycle(0, '0, 1);
        check("t4_pop50", bus.o_pop_data, ent(50, 32'hAAAA));
        cycle(0, '0, 1);
        check("t4_pop80", bus.o_pop_data, ent(80, 32'hCCCC));
        cycle(0, '0, 1);
        check("t4_empty", bus.o_pop_data, '1);
        check("t4_nopop", W'(cap_pop), '0);
        cycle(1, ent(40, 32'h1), 0);
        cycle(1, ent(30, 32'h2), 0);
        cycle(1, ent(60, 32'h3), 0);
        cycle(1, ent(70, 32'h4), 0);
        cycle(1, ent(50, 32'h5), 0);
        check("t5_push0", W'(cap_push), W'(4'b0001));
        check("t5_pushdata", cap_pd, ent(50, 32'h5));
        cycle(0, '0, 1);
        check("t5_pop30", bus.o_pop_data, ent(30, 32'h2));
        cycle(0, '0, 1);
        check("t5_pop0", W'(cap_pop), W'(4'b0001));
        check("t5_refill", bus.o_best_data, ent(50, 32'h5));
        repeat (3) cycle(0, '0, 1);
        cycle(1, ent(7, 32'hA), 0);
        cycle(1, ent(7, 32'hB), 0);
        cycle(0, '0, 1);
        check("t6_tieA", bus.o_pop_data, ent(7, 32'hA));
        cycle(0, '0, 1);
        check("t6_tieB", bus.o_pop_data, ent(7, 32'hB));
        for (int i = 0; i < CAP; i++) cycle(1, rnd_ent(), 0);
        check("sat_ready", W'(bus.o_ready), '0);
        cycle(1, ent(1, 32'hF00D), 0);
        check("sat_ignored", W'(cap_push), '0);
        for (int i = 0; i <= CAP; i++) cycle(0, '0, 1);
        check("sat_drained", bus.o_pop_data, '1);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 99) < 55, rnd_ent(), $urandom_range(0, 99) < 45);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
